key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000: consecutive clocks a key must differ from its debounced state before the change is accepted; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: event FIFO entries; power of two, 2..16.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port keys  input  16  mapped keypad state from the scanner, bit i = 1 means key i pressed; may change on any clock.
REQ-006 Port ev_valid  output  1  FIFO head holds an event.
REQ-007 Port ev_ready  input  1  consumer accepts the head event.
REQ-008 Port ev_code  output  4  key index of the head event.
REQ-009 Port ev_release  output  1  head event is a release (1) or a press (0).
REQ-010 Port held  output  16  debounced key state.
REQ-011 Port overflow  output  1  sticky flag: at least one event was merged or lost.

Function
REQ-012 keys SHALL be registered once (keys_q) before any use; no combinational path from keys to any output.
REQ-013 Each key i SHALL have a debounced bit held[i] and a counter cnt[i]; while keys_q[i]==held[i], cnt[i] clears to 0 every clock.
REQ-014 While keys_q[i]!=held[i], cnt[i] increments every clock; on the clock where cnt[i]==DEBOUNCE_CYCLES-1 and the mismatch persists, held[i] takes keys_q[i], cnt[i] clears, and pend[i] is set with pend_rel[i]=~keys_q[i].
REQ-015 A mismatch lasting fewer than DEBOUNCE_CYCLES clocks SHALL leave held[i] unchanged and create no event.
REQ-016 Arbiter: each clock, select the lowest set pend index; push {index, pend_rel} into the FIFO if it is not full or a pop occurs the same clock; clear that pend bit on push.
REQ-017 At most one push per clock; other pending keys wait with no loss.
REQ-018 If pend[i] is already set when key i produces a new event, the new event SHALL overwrite pend_rel[i] and overflow SHALL be set.
REQ-019 If pend[i] is set and cleared on the same clock, the new event SHALL set pend[i] again; no event is lost.
REQ-020 FIFO: registered storage with first-word fall-through; ev_valid = (count!=0); ev_code/ev_release reflect the head entry whenever ev_valid=1, else 0.
REQ-021 A pop SHALL occur on a clock where ev_valid && ev_ready; head data SHALL stay stable while ev_valid && !ev_ready.
REQ-022 Push and pop on the same clock SHALL leave count unchanged and be legal when the FIFO is full or holds one entry; a push to an empty FIFO is not visible until the next clock.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-024 Latency: keys changes before edge E0 -> held and pend updated at edge E0+DEBOUNCE_CYCLES -> ev_valid high after edge E0+DEBOUNCE_CYCLES+1, when the FIFO is not full and no lower-index key is pending.
REQ-025 overflow SHALL stay set until rst.

Reset
REQ-026 With rst=1 at a clock edge: keys_q, held, cnt, pend, pend_rel, FIFO pointers and count SHALL clear to 0, and overflow SHALL clear to 0.
REQ-027 Out of reset: ev_valid=0, ev_code=0, ev_release=0, held=16'h0000, overflow=0; FIFO contents are discarded.
REQ-028 Reset mid-debounce or mid-handshake SHALL abandon all in-progress work; a key still held after reset debounces again as a new press.

Configuration
REQ-029 Macro KEY_RELEASE_EVENT_EN: when defined, release transitions (held 1->0) SHALL generate events with ev_release=1.
REQ-030 When KEY_RELEASE_EVENT_EN is undefined: releases update held but set no pend bit; ev_release SHALL be tied to 0; FIFO entries are 4 bits wide.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4)
REQ-031 keys=16'h0020 held, ev_ready=1 -> held[5]=1 at E0+4, one event with ev_code=5 and ev_release=0, ev_valid high exactly 1 clock.
REQ-032 keys[3] pulses high for 3 clocks -> no event, held stays 16'h0000.
REQ-033 keys changes 0->16'h8101 in one clock, ev_ready=1 -> codes 0, 8, 15 on three consecutive clocks.
REQ-034 ev_ready=0, six distinct key presses -> 4 events queued, 2 pend bits remain; ev_ready=1 -> 6 events in index order; overflow=0.
REQ-035 With KEY_RELEASE_EVENT_EN, press then release key 9 -> events (9, release 0) then (9, release 1); without the macro -> only (9, release 0).
REQ-036 rst asserted while 3 events are queued -> next clock ev_valid=0, overflow=0, held=0.

Source files
------------

// File: rtl/key_event_queue.sv
// Debounces a 16-key keypad and queues press (and optionally release) events in a small FWFT FIFO.
// Optional feature macro: KEY_RELEASE_EVENT_EN (release transitions also produce events).
module key_event_queue #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] keys,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [3:0]  ev_code,
  output logic        ev_release,
  output logic [15:0] held,
  output logic        overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [15:0]    CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef KEY_RELEASE_EVENT_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  logic [15:0]      keys_q;
  logic [15:0]      held_q, held_d;
  logic [15:0]      cnt_q [16];
  logic [15:0]      cnt_d [16];
  logic [15:0]      pend_q, pend_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [EW-1:0]    wr_dat, head;
  logic [15:0]      fire, gen;
  logic             sel_vld, push, pop;
  logic [3:0]       sel_idx;
`ifdef KEY_RELEASE_EVENT_EN
  logic [15:0]      pend_rel_q, pend_rel_d;
`endif

  // A change is accepted on the clock that completes DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    held_d = held_q;
    fire   = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = '0;
      if (keys_q[i] != held_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          held_d[i] = keys_q[i];
          fire[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
`ifdef KEY_RELEASE_EVENT_EN
    gen = fire;
`else
    gen = fire & keys_q;
`endif
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_vld = 1'b1;
        sel_idx = 4'(i);
      end
    end
    pop  = (count_q != '0) && ev_ready;
    push = sel_vld && ((count_q != FULL_CNT) || pop);
`ifdef KEY_RELEASE_EVENT_EN
    wr_dat = {sel_idx, pend_rel_q[sel_idx]};
`else
    wr_dat = sel_idx;
`endif
  end

  // The push clears the pend bit first, so a same-clock new event re-arms it without counting as a merge.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
`ifdef KEY_RELEASE_EVENT_EN
    pend_rel_d = pend_rel_q;
`endif
    if (push) pend_d[sel_idx] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (gen[i]) begin
        if (pend_d[i]) ovf_d = 1'b1;
        pend_d[i] = 1'b1;
`ifdef KEY_RELEASE_EVENT_EN
        pend_rel_d[i] = ~keys_q[i];
`endif
      end
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q   <= '0;
      held_q   <= '0;
      pend_q   <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
`ifdef KEY_RELEASE_EVENT_EN
      pend_rel_q <= '0;
`endif
    end else begin
      keys_q   <= keys;
      held_q   <= held_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
`ifdef KEY_RELEASE_EVENT_EN
      pend_rel_q <= pend_rel_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign head     = mem_q[rd_ptr_q];
  assign ev_valid = (count_q != '0);
  assign ev_code  = ev_valid ? head[EW-1:EW-4] : 4'd0;
`ifdef KEY_RELEASE_EVENT_EN
  assign ev_release = ev_valid & head[0];
`else
  assign ev_release = 1'b0;
`endif
  assign held     = held_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4) with a queue-based reference model.
// Works with or without KEY_RELEASE_EVENT_EN defined.
module tb_key_event_queue;
  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef KEY_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid, ev_release, overflow;
  logic [3:0]  ev_code;
  logic [15:0] held;

  key_event_queue #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .keys(keys), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_release(ev_release), .held(held), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: held flips once the last D registered samples all disagree with it.
  logic [15:0] kq_m, held_m, pend_m, rel_m, fire_m;
  bit          ovf_m, pop_m, all_m;
  int          sel_m;
  logic [4:0]  fq[$];
  logic [15:0] hist[$];

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      kq_m = '0; held_m = '0; pend_m = '0; rel_m = '0; ovf_m = 1'b0;
      fq.delete();
      hist.delete();
    end else begin
      hist.push_back(kq_m);
      if (hist.size() > D) void'(hist.pop_front());
      fire_m = '0;
      if (hist.size() == D) begin
        for (int i = 0; i < 16; i++) begin
          all_m = 1'b1;
          for (int k = 0; k < D; k++) if (hist[k][i] == held_m[i]) all_m = 1'b0;
          fire_m[i] = all_m;
        end
      end
      pop_m = (fq.size() > 0) && ev_ready;
      sel_m = -1;
      for (int i = 15; i >= 0; i--) if (pend_m[i]) sel_m = i;
      if (pop_m) void'(fq.pop_front());
      if (sel_m >= 0 && fq.size() < DEPTH) begin
        fq.push_back({4'(sel_m), rel_m[sel_m]});
        pend_m[sel_m] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        if (fire_m[i]) begin
          held_m[i] = ~held_m[i];
          if (REL_EN || held_m[i]) begin
            if (pend_m[i]) ovf_m = 1'b1;
            pend_m[i] = 1'b1;
            rel_m[i]  = ~held_m[i];
          end
        end
      end
      kq_m = keys;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ev_valid",   32'(ev_valid),   32'(fq.size() > 0));
      chk("ev_code",    32'(ev_code),    fq.size() > 0 ? 32'(fq[0][4:1]) : 32'd0);
      chk("ev_release", 32'(ev_release), fq.size() > 0 ? 32'(fq[0][0])   : 32'd0);
      chk("held",       32'(held),       32'(held_m));
      chk("overflow",   32'(overflow),   32'(ovf_m));
    end
  end

  // Accepted events as rel*16+code, with the cycle they were on the bus.
  int log_e[$];
  int log_c[$];
  int vcnt = 0;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (ev_valid) vcnt++;
      if (ev_valid && ev_ready) begin
        log_e.push_back(int'(ev_release) * 16 + int'(ev_code));
        log_c.push_back(cyc);
      end
    end
  end

  function automatic int ge(input int k);
    return (k < log_e.size()) ? log_e[k] : -1;
  endfunction

  function automatic int gc(input int k);
    return (k < log_c.size()) ? log_c[k] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_e.delete();
    log_c.delete();
    vcnt = 0;
  endtask

  int c0;

  initial begin
    rst = 1'b1;
    step(1);
    chk_en = 1'b1;
    step(1);
    chk("rst_held", 32'(held), 32'h0);
    chk("rst_valid", 32'(ev_valid), 32'h0);
    chk("rst_code", 32'(ev_code), 32'h0);
    rst = 1'b0;

    // Single press of key 5
    clear_log();
    ev_ready = 1'b1;
    keys = 16'h0020;
    c0 = cyc;
    step(12);
    chk("p5_held", 32'(held), 32'h0020);
    chk("p5_count", 32'(log_e.size()), 32'd1);
    chk("p5_event", 32'(ge(0)), 32'd5);
    chk("p5_latency", 32'(gc(0)), 32'(c0 + 6));
    chk("p5_valid_cycles", 32'(vcnt), 32'd1);
    clear_log();
    keys = 16'h0000;
    step(12);
    chk("r5_held", 32'(held), 32'h0);
    chk("r5_count", 32'(log_e.size()), REL_EN ? 32'd1 : 32'd0);

    // Three-clock glitch on key 3
    clear_log();
    keys = 16'h0008;
    step(3);
    keys = 16'h0000;
    step(10);
    chk("glitch_held", 32'(held), 32'h0);
    chk("glitch_count", 32'(log_e.size()), 32'd0);

    // Simultaneous presses drain in index order on consecutive clocks
    clear_log();
    keys = 16'h8101;
    c0 = cyc;
    step(12);
    chk("multi_count", 32'(log_e.size()), 32'd3);
    chk("multi_e0", 32'(ge(0)), 32'd0);
    chk("multi_e1", 32'(ge(1)), 32'd8);
    chk("multi_e2", 32'(ge(2)), 32'd15);
    chk("multi_c0", 32'(gc(0)), 32'(c0 + 6));
    chk("multi_c1", 32'(gc(1)), 32'(c0 + 7));
    chk("multi_c2", 32'(gc(2)), 32'(c0 + 8));
    keys = 16'h0000;
    step(14);

    // Backpressure: six presses, four queued, two pending
    clear_log();
    ev_ready = 1'b0;
    keys = 16'h00FC;
    step(14);
    chk("bp_valid", 32'(ev_valid), 32'd1);
    chk("bp_head", 32'(ev_code), 32'd2);
    chk("bp_model_fifo", 32'(fq.size()), 32'd4);
    chk("bp_model_pend", 32'($countones(pend_m)), 32'd2);
    ev_ready = 1'b1;
    step(12);
    chk("bp_count", 32'(log_e.size()), 32'd6);
    for (int k = 0; k < 6; k++) chk("bp_order", 32'(ge(k)), 32'(k + 2));
    chk("bp_overflow", 32'(overflow), 32'd0);
    keys = 16'h0000;
    step(16);

    // Press then release key 9
    clear_log();
    keys = 16'h0200;
    step(10);
    keys = 16'h0000;
    step(12);
    chk("k9_count", 32'(log_e.size()), REL_EN ? 32'd2 : 32'd1);
    chk("k9_press", 32'(ge(0)), 32'd9);
    chk("k9_release", 32'(ge(1)), REL_EN ? 32'd25 : 32'hFFFF_FFFF);

    // Overflow: key 4 produces a second event while still pending behind a full FIFO
    clear_log();
    ev_ready = 1'b0;
    keys = 16'h000F;
    step(8);
    keys = 16'h001F;
    step(8);
    keys = 16'h000F;
    step(8);
    keys = 16'h001F;
    step(8);
    chk("ovf_set", 32'(overflow), 32'd1);
    ev_ready = 1'b1;
    keys = 16'h0000;
    step(20);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset with three events queued; keys still held re-debounce afterwards
    clear_log();
    ev_ready = 1'b0;
    keys = 16'h0007;
    step(12);
    chk("rq_model_fifo", 32'(fq.size()), 32'd3);
    chk("rq_valid", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    step(1);
    chk("rq_rst_valid", 32'(ev_valid), 32'd0);
    chk("rq_rst_ovf", 32'(overflow), 32'd0);
    chk("rq_rst_held", 32'(held), 32'h0);
    rst = 1'b0;
    clear_log();
    ev_ready = 1'b1;
    step(12);
    chk("rq_count", 32'(log_e.size()), 32'd3);
    for (int k = 0; k < 3; k++) chk("rq_order", 32'(ge(k)), 32'(k));
    chk("rq_held", 32'(held), 32'h0007);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
